// File: rtl/inflight_hazard_tracker.sv
// In-order FIFO scoreboard of in-flight register writers; raises the RAW stall and
// issue handshake at the issue/execute boundary, with partial flush and in-order retire.
module inflight_hazard_tracker #(
    parameter  int DEPTH   = 4,
    parameter  int NUM_SRC = 2,
    parameter  int REG_W   = 5,
    parameter  int FORWARD = 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     issue_valid,
    input  logic [NUM_SRC*REG_W-1:0] issue_rs,
    input  logic [NUM_SRC-1:0]       issue_rs_used,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic                     issue_reg_write,
    input  logic                     issue_is_load,
    output logic                     issue_ready,
    output logic                     hazard_stall,
    input  logic                     retire_valid,
    input  logic                     flush,
    input  logic [CW-1:0]            flush_keep,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty,
    output logic                     underflow_err
);

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_wr;
    logic [DEPTH-1:0]   r_ld;
    logic [REG_W-1:0]   r_rd [DEPTH];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic               r_underflow;

    logic [NUM_SRC-1:0] w_src_stall;
    logic               w_full;
    logic               w_issue;
    logic               w_retire;
    logic [CW-1:0]      w_kept;

    // Walk entries oldest to youngest so the last hit is the youngest writer.
    always_comb begin
        logic [REG_W-1:0] rs;
        logic             hit;
        logic             hit_ld;
        logic [PW-1:0]    idx;
        rs          = '0;
        hit         = 1'b0;
        hit_ld      = 1'b0;
        idx         = '0;
        w_src_stall = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rs     = issue_rs[s*REG_W +: REG_W];
            hit    = 1'b0;
            hit_ld = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                idx = r_head + PW'(k);
                if (r_valid[idx] && r_wr[idx] && (r_rd[idx] != '0) && (r_rd[idx] == rs)) begin
                    hit    = 1'b1;
                    hit_ld = r_ld[idx];
                end
            end
            w_src_stall[s] = issue_rs_used[s] && (rs != '0) && hit && ((FORWARD == 0) || hit_ld);
        end
    end

    assign w_full       = (r_count == CW'(DEPTH));
    assign hazard_stall = issue_valid && (|w_src_stall);
    assign issue_ready  = !w_full && !hazard_stall && !flush;
    assign w_issue      = issue_valid && issue_ready;
    assign w_retire     = retire_valid && (r_count != '0);
    assign w_kept       = (flush_keep < r_count) ? flush_keep : r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid     <= '0;
            r_wr        <= '0;
            r_ld        <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (CW'(k) >= w_kept) begin
                    r_valid[r_head + PW'(k)] <= 1'b0;
                end
            end
            r_tail <= r_head + PW'(w_kept);
            // A retire against a fully flushed queue targets a discarded entry: not an underflow.
            if (retire_valid && (w_kept != '0)) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
                r_count         <= w_kept - CW'(1);
            end else begin
                r_count <= w_kept;
            end
        end else begin
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end else if (retire_valid) begin
                r_underflow <= 1'b1;
            end
            if (w_issue) begin
                r_valid[r_tail] <= 1'b1;
                r_rd[r_tail]    <= issue_rd;
                r_wr[r_tail]    <= issue_reg_write;
                r_ld[r_tail]    <= issue_is_load;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_issue) - CW'(w_retire);
        end
    end

    assign count         = r_count;
    assign full          = w_full;
    assign empty         = (r_count == '0);
    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_inflight_hazard_tracker.sv
// Bench for inflight_hazard_tracker: one instance per forwarding mode, both checked each
// cycle against a queue-based reference, plus directed scenarios with literal expectations.
module tb_inflight_hazard_tracker;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ent_t;
    typedef ent_t ent_q_t[$];

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       issue_valid = 1'b0;
    logic [9:0] issue_rs = '0;
    logic [1:0] issue_rs_used = '0;
    logic [4:0] issue_rd = '0;
    logic       issue_reg_write = 1'b0;
    logic       issue_is_load = 1'b0;
    logic       retire_valid = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] flush_keep = '0;

    logic       rdy0, haz0, full0, empty0, uf0;
    logic       rdy1, haz1, full1, empty1, uf1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    ent_q_t q0, q1;
    bit     muf0, muf1;
    logic   s_haz0, s_haz1, s_rdy0, s_rdy1;

    always #5 CLK = ~CLK;

    inflight_hazard_tracker #(.DEPTH(4), .NUM_SRC(2), .REG_W(5), .FORWARD(0)) u_dut_f0 (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_rs(issue_rs),
        .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
        .issue_is_load(issue_is_load), .issue_ready(rdy0), .hazard_stall(haz0),
        .retire_valid(retire_valid), .flush(flush), .flush_keep(flush_keep),
        .count(cnt0), .full(full0), .empty(empty0), .underflow_err(uf0));

    inflight_hazard_tracker #(.DEPTH(4), .NUM_SRC(2), .REG_W(5), .FORWARD(1)) u_dut_f1 (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_rs(issue_rs),
        .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
        .issue_is_load(issue_is_load), .issue_ready(rdy1), .hazard_stall(haz1),
        .retire_valid(retire_valid), .flush(flush), .flush_keep(flush_keep),
        .count(cnt1), .full(full1), .empty(empty1), .underflow_err(uf1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Youngest matching writer decides; search from the back of the queue.
    function automatic bit m_hazard(input ent_q_t q, input bit fwd, input logic iv,
                                    input logic [9:0] rs, input logic [1:0] used);
        bit st = 0;
        for (int s = 0; s < 2; s++) begin
            logic [4:0] r = rs[s*5 +: 5];
            if (used[s] && r != 0) begin
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].wr && q[j].rd != 0 && q[j].rd == r) begin
                        if (!fwd || q[j].ld) st = 1;
                        break;
                    end
                end
            end
        end
        return iv && st;
    endfunction

    function automatic ent_q_t m_next(input ent_q_t q, input bit do_issue, input ent_t e,
                                      input bit rv, input bit fl, input int fk, inout bit uf);
        ent_q_t n = q;
        if (fl) begin
            int kept = (fk < n.size()) ? fk : n.size();
            while (n.size() > kept) void'(n.pop_back());
            if (rv && kept > 0) void'(n.pop_front());
        end else begin
            if (rv) begin
                if (n.size() > 0) void'(n.pop_front());
                else uf = 1;
            end
            if (do_issue) n.push_back(e);
        end
        return n;
    endfunction

    task automatic step(input logic iv, input logic [9:0] rs, input logic [1:0] used,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic rv, input logic fl, input logic [2:0] fk);
        bit   e_h0, e_h1, e_r0, e_r1;
        ent_t e;
        @(negedge CLK);
        issue_valid = iv; issue_rs = rs; issue_rs_used = used; issue_rd = rd;
        issue_reg_write = wr; issue_is_load = ld; retire_valid = rv; flush = fl; flush_keep = fk;
        #1;
        e_h0 = m_hazard(q0, 0, iv, rs, used);
        e_h1 = m_hazard(q1, 1, iv, rs, used);
        e_r0 = (q0.size() != 4) && !e_h0 && !fl;
        e_r1 = (q1.size() != 4) && !e_h1 && !fl;
        chk("haz_f0", int'(haz0), int'(e_h0));
        chk("rdy_f0", int'(rdy0), int'(e_r0));
        chk("cnt_f0", int'(cnt0), q0.size());
        chk("full_f0", int'(full0), int'(q0.size() == 4));
        chk("empty_f0", int'(empty0), int'(q0.size() == 0));
        chk("uf_f0", int'(uf0), int'(muf0));
        chk("haz_f1", int'(haz1), int'(e_h1));
        chk("rdy_f1", int'(rdy1), int'(e_r1));
        chk("cnt_f1", int'(cnt1), q1.size());
        chk("full_f1", int'(full1), int'(q1.size() == 4));
        chk("empty_f1", int'(empty1), int'(q1.size() == 0));
        chk("uf_f1", int'(uf1), int'(muf1));
        s_haz0 = haz0; s_haz1 = haz1; s_rdy0 = rdy0; s_rdy1 = rdy1;
        e = '{rd: rd, wr: wr, ld: ld};
        @(posedge CLK);
        q0 = m_next(q0, iv && e_r0, e, rv, fl, int'(fk), muf0);
        q1 = m_next(q1, iv && e_r1, e, rv, fl, int'(fk), muf1);
        #1;
    endtask

    task automatic idle();
        step(0, '0, '0, '0, 0, 0, 0, 0, '0);
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr, input logic ld);
        step(1, '0, '0, rd, wr, ld, 0, 0, '0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next rising edge.
    task automatic do_reset();
        @(negedge CLK);
        issue_valid = 0; issue_rs_used = '0; retire_valid = 0; flush = 0;
        #2 nRST = 0;
        #1;
        chk("rst_cnt_f0", int'(cnt0), 0);
        chk("rst_empty_f0", int'(empty0), 1);
        chk("rst_full_f0", int'(full0), 0);
        chk("rst_uf_f0", int'(uf0), 0);
        chk("rst_cnt_f1", int'(cnt1), 0);
        chk("rst_uf_f1", int'(uf1), 0);
        chk("rst_haz_f1", int'(haz1), 0);
        q0.delete(); q1.delete(); muf0 = 0; muf1 = 0;
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        issue_valid = 1;
        #1;
        chk("init_empty", int'(empty0), 1);
        chk("init_ready", int'(rdy0), 1);
        chk("init_haz", int'(haz1), 0);
        issue_valid = 0;
        nRST = 1;

        // 1: non-forwarding stall on any writer, cleared by retire
        do_reset();
        issue(5, 1, 0);
        step(1, {5'd0, 5'd5}, 2'b01, 5'd0, 0, 0, 0, 0, '0);
        chk("t1_haz_f0", int'(s_haz0), 1);
        chk("t1_rdy_f0", int'(s_rdy0), 0);
        chk("t1_haz_f1", int'(s_haz1), 0);
        do_reset();
        issue(5, 1, 0);
        step(0, '0, '0, '0, 0, 0, 1, 0, '0);
        chk("t1_cnt_after_retire", int'(cnt0), 0);
        step(1, {5'd0, 5'd5}, 2'b01, 5'd0, 0, 0, 0, 0, '0);
        chk("t1_haz_cleared", int'(s_haz0), 0);

        // 2: younger ALU writer shadows older load under forwarding
        do_reset();
        issue(7, 1, 1);
        issue(7, 1, 0);
        step(1, {5'd7, 5'd0}, 2'b10, 5'd0, 0, 0, 0, 0, '0);
        chk("t2_shadow_f1", int'(s_haz1), 0);
        chk("t2_shadow_f0", int'(s_haz0), 1);
        do_reset();
        issue(7, 1, 1);
        step(1, {5'd0, 5'd7}, 2'b01, 5'd0, 0, 0, 0, 0, '0);
        chk("t2_loaduse_f1", int'(s_haz1), 1);

        // 3: full blocks issue even with retire; pointer wrap
        do_reset();
        repeat (4) issue(0, 0, 0);
        chk("t3_full", int'(full1), 1);
        step(1, '0, '0, 5'd0, 0, 0, 1, 0, '0);
        chk("t3_rdy_full", int'(s_rdy1), 0);
        chk("t3_cnt3", int'(cnt1), 3);
        for (int i = 0; i < 9; i++) step(1, '0, '0, 5'(i + 1), 1, 0, 1, 0, '0);
        chk("t3_cnt_wrap", int'(cnt1), 3);

        // 4: flush with retire, and over-large keep
        do_reset();
        repeat (4) issue(3, 1, 1);
        step(0, '0, '0, '0, 0, 0, 1, 1, 3'd1);
        chk("t4_cnt0", int'(cnt0), 0);
        chk("t4_uf0", int'(uf0), 0);
        issue(3, 1, 0);
        issue(4, 1, 0);
        step(0, '0, '0, '0, 0, 0, 0, 1, 3'd6);
        chk("t4_keep_all", int'(cnt1), 2);
        step(0, '0, '0, '0, 0, 0, 1, 1, 3'd0);
        chk("t4_flush0_uf", int'(uf1), 0);

        // 5: sticky underflow
        do_reset();
        step(0, '0, '0, '0, 0, 0, 1, 0, '0);
        idle();
        chk("t5_uf_sticky", int'(uf0), 1);
        issue(2, 1, 0);
        issue(6, 1, 1);

        // 6: r0 writer and unused source never stall
        do_reset();
        issue(0, 1, 1);
        step(1, {5'd0, 5'd0}, 2'b01, 5'd0, 0, 0, 0, 0, '0);
        chk("t6_r0_f0", int'(s_haz0), 0);
        do_reset();
        issue(3, 1, 1);
        step(1, {5'd3, 5'd3}, 2'b00, 5'd0, 0, 0, 0, 0, '0);
        chk("t6_unused", int'(s_haz1), 0);
        step(1, {5'd3, 5'd3}, 2'b10, 5'd0, 0, 0, 0, 0, '0);
        chk("t6_used_f1", int'(s_haz1), 1);

        // randomized traffic over a narrow register range to provoke matches
        for (int n = 0; n < 2400; n++) begin
            if (n % 600 == 599) do_reset();
            step(($urandom_range(0, 9) < 7),
                 {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 99) < 8),
                 3'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
